// File: rtl/ft232h_pkg.sv
// Shared definitions for the FT232H synchronous FIFO (FT245-sync) datapath.
package ft232h_pkg;

    // FT232H data bus width
    localparam int FT_DW = 8;

    // Statistics counter widths (used when FT232H_RX_STATS_EN is defined)
    localparam int RX_BYTE_CNT_W  = 32;
    localparam int RX_BURST_CNT_W = 16;

    // Bus-side state: IDLE -> OE (turnaround) -> READ (burst) -> REL (release)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OE   = 2'd1,
        READ = 2'd2,
        REL  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/ft232h_rx_fifo.sv
// Single-clock show-ahead byte FIFO. Head byte is always visible on rd_data;
// rd_en advances the head. Callers must not write when full or read when empty.
module ft232h_rx_fifo
    import ft232h_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [FT_DW-1:0] wr_data,
    input  logic             rd_en,
    output logic [FT_DW-1:0] rd_data,
    output logic [AW:0]      cnt,
    output logic             empty
);

    logic [DEPTH-1:0][FT_DW-1:0] mem;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;

    // Storage, pointers (wrap naturally at DEPTH) and occupancy; reset discards contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_en)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (cnt == '0);

endmodule

// File: rtl/ft232h_rx.sv
// FT232H sync-FIFO receive path: sequences OE#/RD#, captures bus bytes into
// a local FIFO and presents them as a valid/ready byte stream.
// Optional byte/burst statistics outputs: define FT232H_RX_STATS_EN.
module ft232h_rx
    import ft232h_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rxf_n,
    input  logic [FT_DW-1:0] data_in,
    output logic             oe_n,
    output logic             rd_n,
    input  logic             bus_gnt,
    output logic             bus_busy,
    output logic [FT_DW-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef FT232H_RX_STATS_EN
   ,output logic [RX_BYTE_CNT_W-1:0]  rx_byte_count,
    output logic [RX_BURST_CNT_W-1:0] rx_burst_count
`endif
);

    localparam int AW = $clog2(DEPTH);

    rx_state_e     state, state_nx;
    logic          cap;
    logic          pop;
    logic          space_ok;
    logic          fifo_empty;
    logic [AW:0]   cnt;
    logic [AW+1:0] occ_nx;

    // A byte is on the bus only while we strobe RD# and the chip still has data
    assign cap      = (state == READ) & ~rd_n & ~rxf_n;
    assign pop      = out_valid & out_ready;
    // Conservative room check: ignores a same-cycle pop
    assign occ_nx   = {1'b0, cnt} + {{(AW+1){1'b0}}, cap};
    assign space_ok = occ_nx < (AW+2)'(DEPTH);
    assign bus_busy = (state != IDLE);
    assign out_valid = ~fifo_empty;

    // Next-state logic for the bus handshake
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (~rxf_n & bus_gnt & space_ok) state_nx = OE;
            OE:   state_nx = (~rxf_n & space_ok & bus_gnt) ? READ : REL;
            READ: if (!(~rxf_n & space_ok & bus_gnt)) state_nx = REL;
            REL:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Glitch-free strobes registered from the next state; RD# drops only in READ
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oe_n <= 1'b1;
            rd_n <= 1'b1;
        end else begin
            oe_n <= (state_nx == IDLE);
            rd_n <= (state_nx != READ);
        end
    end

    ft232h_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (cap),
        .wr_data (data_in),
        .rd_en   (pop),
        .rd_data (out_data),
        .cnt     (cnt),
        .empty   (fifo_empty)
    );

`ifdef FT232H_RX_STATS_EN
    // Free-running statistics: bytes captured and READ bursts entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_byte_count  <= '0;
            rx_burst_count <= '0;
        end else begin
            if (cap)
                rx_byte_count <= rx_byte_count + RX_BYTE_CNT_W'(1);
            if ((state != READ) && (state_nx == READ))
                rx_burst_count <= rx_burst_count + RX_BURST_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ft232h_rx.sv
// Self-checking bench for ft232h_rx: an FT232H host model feeds bytes, a
// byte-order scoreboard plus handshake rules check the DUT every cycle.
module tb_ft232h_rx;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n, rxf_n, bus_gnt, out_ready;
    logic [7:0] data_in;
    logic       oe_n, rd_n, bus_busy, out_valid;
    logic [7:0] out_data;
`ifdef FT232H_RX_STATS_EN
    logic [31:0] rx_byte_count;
    logic [15:0] rx_burst_count;
`endif

    ft232h_rx #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxf_n     (rxf_n),
        .data_in   (data_in),
        .oe_n      (oe_n),
        .rd_n      (rd_n),
        .bus_gnt   (bus_gnt),
        .bus_busy  (bus_busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef FT232H_RX_STATS_EN
       ,.rx_byte_count  (rx_byte_count),
        .rx_burst_count (rx_burst_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] hq[$];   // bytes the chip still holds
    logic [7:0] sq[$];   // bytes the DUT should be buffering, oldest first
    bit  force_hi = 0, toggle_en = 0, exp_oe_hi = 0;
    bit  p_oe = 1, pp_oe = 1, p_rd = 1;
    int  takes = 0, rd_falls = 0, toggle_base = 0;
    int  stat_bytes = 0, stat_bursts = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Chip side: RXF# low while bytes are pending; bus is junk otherwise
    task automatic drive_host();
        rxf_n   = (hq.size() == 0) || force_hi;
        data_in = (hq.size() != 0) ? hq[0] : 8'($urandom);
    endtask

    // One clock: sample before the edge, advance models, check rules after it
    task automatic tick();
        bit take, popped, gnt_b, rxf_b;
        int occ_after;
        take      = !rd_n && !rxf_n;
        popped    = out_valid && out_ready;
        gnt_b     = bus_gnt;
        rxf_b     = rxf_n;
        occ_after = sq.size() + (take ? 1 : 0);
        pp_oe = p_oe; p_oe = oe_n; p_rd = rd_n;
        chk("valid_pre", 32'(out_valid), 32'(sq.size() != 0));
        if (popped && sq.size() != 0) chk("out_data", 32'(out_data), 32'(sq[0]));
        @(posedge clk); #1;
        if (popped && sq.size() != 0) void'(sq.pop_front());
        if (take) begin
            sq.push_back(hq.pop_front());
            takes++; stat_bytes++;
        end
        chk("no_overflow", 32'(sq.size() <= DEPTH), 32'd1);
        if (!rd_n) begin
            chk("rd_cond", {29'd0, gnt_b, rxf_b, occ_after < DEPTH}, 32'b101);
            chk("rd_implies_oe", 32'(oe_n), 32'd0);
        end
        if (p_oe && !oe_n) chk("oe_cond", {30'd0, gnt_b, rxf_b}, 32'b10);
        if (p_rd && !rd_n) begin
            rd_falls++; stat_bursts++;
            chk("turnaround", {30'd0, pp_oe, p_oe}, 32'b10);
        end
        if (exp_oe_hi) chk("rel_one_cycle", 32'(oe_n), 32'd1);
        exp_oe_hi = !p_rd && rd_n;
        if (exp_oe_hi) chk("rd_before_oe", 32'(oe_n), 32'd0);
        chk("busy", 32'(bus_busy), 32'(!oe_n));
`ifdef FT232H_RX_STATS_EN
        chk("stat_bytes", rx_byte_count, 32'(stat_bytes));
        chk("stat_bursts", 32'(rx_burst_count), 32'(stat_bursts & 16'hFFFF));
`endif
        force_hi = toggle_en && take && ((takes - toggle_base) % 3 == 0);
        drive_host();
    endtask

    task automatic drain(input string tag, input int bound);
        int n = 0;
        while ((hq.size() != 0 || sq.size() != 0 || bus_busy) && n < bound) begin
            tick(); n++;
        end
        chk({tag, "_host_empty"}, 32'(hq.size()), 32'd0);
        chk({tag, "_fifo_empty"}, 32'(sq.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_oe_n", 32'(oe_n), 32'd1);
        chk("rst_rd_n", 32'(rd_n), 32'd1);
        chk("rst_busy", 32'(bus_busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        sq.delete();
        exp_oe_hi = 0; force_hi = 0;
        stat_bytes = 0; stat_bursts = 0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        drive_host();
    endtask

    initial begin
        int t0, f0, n;
        rst_n = 1'b0; rxf_n = 1'b1; data_in = 8'h00; bus_gnt = 1'b0; out_ready = 1'b0;
        #12;
        chk("reset_oe_n", 32'(oe_n), 32'd1);
        chk("reset_rd_n", 32'(rd_n), 32'd1);
        chk("reset_busy", 32'(bus_busy), 32'd0);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_data", 32'(out_data), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // 5-byte burst: latency and ordering
        bus_gnt = 1; out_ready = 1;
        for (int i = 0; i < 5; i++) hq.push_back(8'hA0 + 8'(i));
        drive_host();
        tick(); chk("t1_oe_edge1", 32'(oe_n), 32'd0); chk("t1_rd_edge1", 32'(rd_n), 32'd1);
        tick(); chk("t1_rd_edge2", 32'(rd_n), 32'd0); chk("t1_valid_edge2", 32'(out_valid), 32'd0);
        tick(); chk("t1_valid_edge3", 32'(out_valid), 32'd1); chk("t1_first", 32'(out_data), 32'hA0);
        drain("t1", 40);
        chk("t1_takes", 32'(takes), 32'd5);
        chk("t1_oe_idle", 32'(oe_n), 32'd1);

        // Sink stalled: burst stops at DEPTH, then resumes cleanly
        out_ready = 0; t0 = takes;
        for (int i = 0; i < 40; i++) hq.push_back(8'(i + 1));
        drive_host();
        for (int i = 0; i < 60; i++) tick();
        chk("t2_full_cnt", 32'(sq.size()), 32'(DEPTH));
        chk("t2_rd_high", 32'(rd_n), 32'd1);
        chk("t2_valid", 32'(out_valid), 32'd1);
        out_ready = 1;
        drain("t2", 300);
        chk("t2_takes", 32'(takes - t0), 32'd40);

        // RXF# blips high every 3 bytes: each one forces a fresh burst
        toggle_en = 1; toggle_base = takes; f0 = rd_falls;
        for (int i = 0; i < 12; i++) hq.push_back(8'($urandom));
        drive_host();
        drain("t3", 200);
        chk("t3_bursts", 32'(rd_falls - f0), 32'd4);
        toggle_en = 0; force_hi = 0;

        // No grant: bus stays untouched; grant dropped mid-READ: one more byte
        bus_gnt = 0;
        for (int i = 0; i < 8; i++) hq.push_back(8'($urandom));
        drive_host();
        for (int i = 0; i < 10; i++) tick();
        chk("t4_oe_nogrant", 32'(oe_n), 32'd1);
        chk("t4_rd_nogrant", 32'(rd_n), 32'd1);
        chk("t4_takes_nogrant", 32'(hq.size()), 32'd8);
        bus_gnt = 1; n = 0;
        while (rd_n && n < 10) begin tick(); n++; end
        chk("t4_rd_timeout", 32'(rd_n), 32'd0);
        bus_gnt = 0; t0 = takes;
        for (int i = 0; i < 5; i++) tick();
        chk("t4_one_more", 32'(takes - t0), 32'd1);
        chk("t4_released", 32'(oe_n), 32'd1);
        bus_gnt = 1;
        drain("t4", 100);

        // Reset in the middle of a burst, then a normal burst
        for (int i = 0; i < 10; i++) hq.push_back(8'hC0 + 8'(i));
        drive_host();
        n = 0;
        while (rd_n && n < 10) begin tick(); n++; end
        tick(); tick();
        chk("t5_in_burst", 32'(rd_n), 32'd0);
        #2;
        do_reset();
        chk("t5_post_valid", 32'(out_valid), 32'd0);
        drain("t5", 100);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            bus_gnt   = ($urandom_range(9) != 0);
            out_ready = ($urandom_range(9) < 7);
            if (hq.size() < 30 && $urandom_range(9) < 4) begin
                hq.push_back(8'($urandom));
                if (hq.size() == 1) drive_host();
            end
            tick();
        end
        bus_gnt = 1; out_ready = 1;
        drain("rnd", 400);

`ifdef FT232H_RX_STATS_EN
        // Three 4-byte bursts from a fresh reset
        do_reset();
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 4; i++) hq.push_back(8'($urandom));
            drive_host();
            drain("t6", 60);
        end
        chk("t6_byte_count", rx_byte_count, 32'd12);
        chk("t6_burst_count", 32'(rx_burst_count), 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ft232h_rx.md
Name: ft232h_rx

Overview:
- Receive path of the FT232H synchronous FIFO (FT245-sync) interface: USB host → FT232H → this block → downstream stream sink.
- Drives oe_n/rd_n, captures bytes from the data bus while the chip signals data available (rxf_n low), and buffers them in an internal FIFO.
- Presents buffered bytes on a valid/ready byte stream.
- Runs entirely in the FT232H 60 MHz CLKOUT domain. Shares the data bus with the transmit path through a grant input.

Parameters:
- DEPTH, 16, internal FIFO entries; power of 2, minimum 4.
- AW, $clog2(DEPTH), FIFO pointer width; derived, not overridden.

Ports:
- clk  in  1  FT232H CLKOUT, 60 MHz; all logic on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- rxf_n  in  1  FT232H RXF#; low = chip holds unread bytes.
- data_in  in  8  FT232H data bus, input side of the pad.
- oe_n  out  1  FT232H OE#; low = chip drives the bus.
- rd_n  out  1  FT232H RD#; low = read strobe.
- bus_gnt  in  1  bus arbiter grant; high = receive side may take the bus.
- bus_busy  out  1  high while this block owns the bus (state != IDLE).
- out_data  out  8  head byte of the FIFO.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  sink accepts out_data this cycle.

Behaviour:
- Reset values: oe_n=1, rd_n=1, bus_busy=0, out_valid=0, out_data=0, FIFO empty, state=IDLE.
- oe_n and rd_n are registered and decoded from the state register only. No combinational path from inputs.
- cnt = FIFO occupancy (0..DEPTH). space_ok = (cnt + cap) < DEPTH, where cap is this cycle's capture. Pops are ignored for this check (conservative).
- cap = (state==READ) & ~rd_n & ~rxf_n. When cap is high, data_in is written to the FIFO on that edge.
- State machine:
  - IDLE (oe_n=1, rd_n=1): go to OE when ~rxf_n & bus_gnt & space_ok.
  - OE (oe_n=0, rd_n=1): one-cycle bus turnaround. Go to READ if ~rxf_n & space_ok & bus_gnt, else go to REL.
  - READ (oe_n=0, rd_n=0): stay while ~rxf_n & space_ok & bus_gnt. Otherwise go to REL. The byte on the exit edge is still captured if cap is high.
  - REL (oe_n=0, rd_n=1): exactly one cycle, then IDLE. RD# always deasserts before OE#.
- Latency: first byte is captured on the 3rd rising edge after rxf_n is sampled low in IDLE. out_valid rises the cycle after capture. Sustained throughput is 1 byte/clk.
- FIFO: out_valid = (cnt != 0). out_data = mem[rd_ptr], registered/show-ahead.
  - pop = out_valid & out_ready.
  - Simultaneous cap and pop leave cnt unchanged.
  - Pointers wrap modulo DEPTH.
  - No overflow is possible: cap only happens when space_ok was true on the previous edge.
- rxf_n rising mid-burst: a byte is captured only on edges where rxf_n is low. Go to REL next.
- FIFO full mid-burst: rd_n deasserts on the edge where space_ok goes false. No byte is lost or duplicated.
- bus_gnt low mid-burst: same exit path via REL. The byte on that edge is kept.
- out_ready held low: burst stalls at DEPTH bytes. Resume requires a fresh IDLE→OE→READ sequence.
- rst_n asserted mid-burst: oe_n and rd_n go high immediately (async). FIFO contents are discarded.

Optional Feature:
- Macro: FT232H_RX_STATS_EN.
- Defined: adds outputs rx_byte_count (32 bits, +1 per cap, wraps at 2^32) and rx_burst_count (16 bits, +1 per entry into READ, wraps). Both reset to 0.
- Undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package ft232h_pkg:
  - state encoding: IDLE=2'd0, OE=2'd1, READ=2'd2, REL=2'd3.
  - bus width constant FT_DW=8.
  - stats counter widths.
- Sub-module ft232h_rx_fifo: single-clock FIFO, DEPTH×8, with wr/rd/cnt/empty. Reusable by a future single-clock transmit staging buffer.

Test Plan:
- rxf_n low for 5 bytes (0xA0..0xA4), bus_gnt=1, out_ready=1 → oe_n falls edge 1, rd_n falls edge 2; bytes A0..A4 appear in order on out_data; rd_n rises, then oe_n one cycle later; bus_busy low after REL.
- out_ready=0, rxf_n held low, 40 bytes pending, DEPTH=16 → exactly 16 bytes captured, rd_n high with cnt=16. Then out_ready=1 → 16 in order, new burst starts, bytes 17..40 continue without gap or duplicate.
- rxf_n toggles high for 1 cycle every 3 bytes → no capture on rxf_n-high edges; each toggle produces REL→IDLE→OE re-entry; data order preserved.
- bus_gnt=0 with rxf_n low → oe_n and rd_n stay 1, bus_busy=0. Drop bus_gnt mid-READ → one more byte max, then REL.
- rst_n pulsed low mid-burst → oe_n=rd_n=1 asynchronously, out_valid=0. After release, a normal burst resumes.
- With FT232H_RX_STATS_EN: 3 bursts of 4 bytes → rx_byte_count=12, rx_burst_count=3.
